spi_reg_responder: RTL

SPI target (responder) in the FPGA fabric answering the HPS SPI master, which is the initiator. It exposes a four-register, 8-bit map: LED drive, switch/button status, scratch and a frame counter. SPI pins run through GPIO header lines. The block sits beside the LED/button PIO logic and oversamples SPI on the 50 MHz fabric clock, with no SCK-domain logic.

---
 rtl/spi_reg_responder.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_responder.sv
// rtl/spi_reg_responder.sv - SPI mode-0 register responder oversampled on the fabric clock
//
// Purpose:
//   SPI target answering the HPS SPI master. It serves a 4 x 8-bit register map
//   (LED, switch/button status, scratch, frame counter). All SPI pins are
//   synchronized into fpga_clk_50 and edges are detected there. No logic runs
//   on the SCK domain.
//
//   Frame = 16 bits, MSB first. Byte 0 is the command: [7] write, [1:0] addr.
//   Byte 1 is write data. The addressed register is snapshotted on the 8th
//   rising edge and shifted out on MISO during byte 1. Writes and the
//   frame-count increment commit on the 16th rising edge.
//
// Ports:
//   fpga_clk_50      in   fabric clock (50 MHz)
//   hps_fpga_reset_n in   asynchronous active-low reset
//   spi_sck          in   SPI clock, mode 0
//   spi_cs_n         in   chip select, active-low
//   spi_mosi         in   serial data from initiator
//   spi_miso         out  serial data to initiator
//   spi_miso_oe      out  MISO tristate enable, high while synchronized CS is low
//   sw_in[3:0]       in   slide switches
//   key_in[1:0]      in   debounced buttons
//   led_out[6:0]     out  reg0[6:0]
//   wr_pulse         out  one-cycle strobe on each committed write
//   wr_addr[1:0]     out  address of the last committed write

module spi_reg_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       fpga_clk_50,
  input  logic       hps_fpga_reset_n,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [3:0] sw_in,
  input  logic [1:0] key_in,
  output logic [6:0] led_out,
  output logic       wr_pulse,
  output logic [1:0] wr_addr
);

  // Fewer than two stages is not a safe synchronizer; clamp silently.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // ------------------------------------------------------------------
  // Synchronizers and edge detection
  // ------------------------------------------------------------------
  logic [STAGES-1:0] sck_sync;
  logic [STAGES-1:0] cs_sync;
  logic [STAGES-1:0] mosi_sync;
  logic              sck_prev;
  logic              cs_armed;

  // The CS chain resets to 0 (asserted-looking). Together with cs_armed this
  // means that a frame interrupted by reset is not resumed: a new frame is only
  // accepted after CS has been seen high at least once since reset.
  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
      cs_armed  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[STAGES-2:0], spi_mosi};
      sck_prev  <= sck_sync[STAGES-1];
      if (cs_sync[STAGES-1]) begin
        cs_armed <= 1'b1;
      end
    end
  end

  logic sck_s;
  logic cs_low;
  logic mosi_s;
  logic sck_rise;
  logic sck_fall;

  assign sck_s    = sck_sync[STAGES-1];
  assign cs_low   = ~cs_sync[STAGES-1];
  assign mosi_s   = mosi_sync[STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;

  // ------------------------------------------------------------------
  // Frame state machine
  // ------------------------------------------------------------------
  state_t     state;
  state_t     state_nxt;
  logic [4:0] bit_cnt;
  logic       sample;
  logic       snap;
  logic       commit;
  logic       shift_out;

  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    snap      = 1'b0;
    commit    = 1'b0;
    shift_out = 1'b0;

    case (state)
      S_IDLE: begin
        if (cs_low && cs_armed) begin
          state_nxt = S_CMD;
        end
      end
      S_CMD: begin
        if (sck_rise) begin
          sample = 1'b1;
          if (bit_cnt == 5'd7) begin
            snap      = 1'b1;
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        shift_out = sck_fall;
        if (sck_rise) begin
          sample = 1'b1;
          if (bit_cnt == 5'd15) begin
            commit    = 1'b1;
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Extra edges past bit 16 are ignored until CS rises.
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // CS high aborts everything, whatever the state.
    if (!cs_low) begin
      state_nxt = S_IDLE;
      sample    = 1'b0;
      snap      = 1'b0;
      commit    = 1'b0;
      shift_out = 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // Register file
  // ------------------------------------------------------------------
  logic [7:0] reg0;
  logic [7:0] reg2;
  logic [7:0] reg3;
  logic [7:0] status;
  logic [1:0] snap_addr;
  logic [7:0] rd_data;

  assign status  = {2'b00, key_in, sw_in};
  assign led_out = reg0[6:0];

  always_comb begin
    case (snap_addr)
      2'd0:    rd_data = reg0;
      2'd1:    rd_data = status;
      2'd2:    rd_data = reg2;
      default: rd_data = reg3;
    endcase
  end

  // ------------------------------------------------------------------
  // Shift datapath
  // ------------------------------------------------------------------
  // rx holds the last seven received bits; the eighth arrives as mosi_s on
  // the same edge, so a complete byte is {rx, mosi_s}.
  logic [6:0] rx;
  logic [7:0] tx;
  logic       cmd_wr;
  logic [1:0] cmd_addr;
  logic [7:0] wr_data;
  logic       wr_ok;

  assign snap_addr = {rx[0], mosi_s};
  assign wr_data   = {rx, mosi_s};
  assign wr_ok     = cmd_wr & ~cmd_addr[0];

  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) begin
      bit_cnt  <= 5'd0;
      rx       <= 7'd0;
      tx       <= 8'd0;
      cmd_wr   <= 1'b0;
      cmd_addr <= 2'd0;
      spi_miso <= 1'b0;
    end else begin
      if (!cs_low) begin
        bit_cnt  <= 5'd0;
        spi_miso <= 1'b0;
      end else begin
        if (sample) begin
          bit_cnt <= bit_cnt + 5'd1;
          rx      <= {rx[5:0], mosi_s};
        end
        if (snap) begin
          cmd_wr   <= rx[6];
          cmd_addr <= snap_addr;
          tx       <= rd_data;
        end
        if (shift_out) begin
          spi_miso <= tx[7];
          tx       <= {tx[6:0], 1'b0};
        end else if (sck_fall) begin
          spi_miso <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) begin
      reg0        <= 8'd0;
      reg2        <= 8'd0;
      reg3        <= 8'd0;
      wr_pulse    <= 1'b0;
      wr_addr     <= 2'd0;
      spi_miso_oe <= 1'b0;
    end else begin
      wr_pulse    <= 1'b0;
      spi_miso_oe <= cs_low & cs_armed;
      if (commit) begin
        reg3 <= reg3 + 8'd1;
        if (wr_ok) begin
          wr_pulse <= 1'b1;
          wr_addr  <= cmd_addr;
          if (cmd_addr[1]) begin
            reg2 <= wr_data;
          end else begin
            reg0 <= wr_data;
          end
        end
      end
    end
  end

endmodule
